// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: instruction sequencer driving the 26-bit core inst word.
// Owns kmem load/feed, double-buffered qmem fill/stream, execute and pmem drain.
// Ports:
//   clk, reset              clock, async active-high reset
//   start, load_kernel      job launch (accepted in IDLE only)
//   k_valid / k_ready       kernel row handshake
//   q_valid / q_ready       query row handshake
//   fifo_valid              ofifo holds at least one row
//   inst [25:0]             registered core instruction word
//   busy, done              job active / last pmem row written
module core_seq_ctrl #(
    parameter int LEN    = 8,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_kernel,
    input  logic        k_valid,
    output logic        k_ready,
    input  logic        q_valid,
    output logic        q_ready,
    input  logic        fifo_valid,
    output logic [25:0] inst,
    output logic        busy,
    output logic        done
);

    // EXEC is split into a fill wait, the bank swap cycle and the read run.
    typedef enum logic [2:0] {
        IDLE, KLOAD, KFEED, EXEC, SWAP, RUN, DRAIN, DONE
    } state_t;

    localparam int            CW    = 5;
    localparam logic [CW-1:0] LEN_C = CW'(LEN);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [CW-1:0]     fill_cnt, fill_cnt_n;
    logic [ADDR_W-1:0] pmem_ptr, pmem_ptr_n;
    logic              rsel, rsel_n;
    logic [25:0]       inst_n;
    logic              k_acc, q_acc, fill_full;

    // Every inst field is decided from this cycle's state and inputs and
    // shows up registered one cycle later.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        fill_cnt_n = fill_cnt;
        pmem_ptr_n = pmem_ptr;
        rsel_n     = rsel;
        inst_n     = '0;
        k_acc      = k_valid && k_ready;
        q_acc      = q_valid && q_ready;
        fill_full  = (fill_cnt == LEN_C);

        // Kernel load / execute trail their SRAM reads by one cycle.
        inst_n[6] = inst[3];
        inst_n[7] = inst[5];

        if (q_acc) begin
            inst_n[4]     = 1'b1;
            inst_n[24:21] = 4'(fill_cnt);
            fill_cnt_n    = fill_cnt + ONE;
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_n   = '0;
                    state_n = load_kernel ? KLOAD : EXEC;
                end
            end
            KLOAD: begin
                if (k_acc) begin
                    inst_n[2]     = 1'b1;
                    inst_n[16:13] = 4'(cnt);
                    if (cnt == LEN_C - ONE) begin
                        cnt_n   = '0;
                        state_n = KFEED;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            KFEED: begin
                if (cnt == LEN_C) begin
                    cnt_n   = '0;
                    state_n = EXEC;
                end else begin
                    inst_n[3]     = 1'b1;
                    inst_n[16:13] = 4'(cnt);
                    cnt_n         = cnt + ONE;
                end
            end
            EXEC: begin
                if (fill_full) begin
                    rsel_n     = !rsel;
                    fill_cnt_n = '0;
                    state_n    = SWAP;
                end
            end
            SWAP: begin
                cnt_n   = '0;
                state_n = RUN;
            end
            RUN: begin
                if (cnt == LEN_C) begin
                    cnt_n   = '0;
                    state_n = DRAIN;
                end else begin
                    inst_n[5]     = 1'b1;
                    inst_n[20:17] = 4'(cnt);
                    cnt_n         = cnt + ONE;
                end
            end
            DRAIN: begin
                if (fifo_valid) begin
                    inst_n[12]   = 1'b1;
                    inst_n[0]    = 1'b1;
                    inst_n[11:8] = 4'(pmem_ptr);
                    pmem_ptr_n   = pmem_ptr + ADDR_W'(1);
                    if (cnt == LEN_C - ONE) begin
                        cnt_n   = '0;
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
        endcase

        inst_n[25] = rsel_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            fill_cnt <= '0;
            pmem_ptr <= '0;
            rsel     <= 1'b0;
            inst     <= '0;
            k_ready  <= 1'b0;
            q_ready  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            fill_cnt <= fill_cnt_n;
            pmem_ptr <= pmem_ptr_n;
            rsel     <= rsel_n;
            inst     <= inst_n;
            k_ready  <= (state_n == KLOAD);
            // mem_in is shared, so q_ready stays low whenever k_ready can be high.
            q_ready  <= (fill_cnt_n != LEN_C) &&
                        !(state_n inside {KLOAD, KFEED, SWAP});
            busy     <= (state_n != IDLE);
            done     <= (state_n == DONE);
        end
    end

endmodule
